// File: rtl/ws2812_pkg.sv
// WS2812 timing constants shared by the transmitter and receiver,
// plus the receiver FSM state encoding.
package ws2812_pkg;

  localparam int unsigned ZERO_HIGH_TICKS = 20;
  localparam int unsigned ZERO_LOW_TICKS  = 42;
  localparam int unsigned ONE_HIGH_TICKS  = 40;
  localparam int unsigned ONE_LOW_TICKS   = 22;
  localparam int unsigned LATCH_TICKS     = 2500;

  localparam int unsigned BIT_SPLIT_TICKS =
    (ZERO_HIGH_TICKS + ONE_HIGH_TICKS) / 2;

  localparam int unsigned WORD_BITS = 24;
  localparam int unsigned IDX_W     = 16;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } rx_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic grb_t to_grb(input logic [WORD_BITS-1:0] w);
    grb_t c;
    c.g = w[23:16];
    c.r = w[15:8];
    c.b = w[7:0];
    return c;
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Pixel-side bundle of the WS2812 receiver: serial line in/out
// and decoded colour/status outputs.
interface ws2812_rx_if;
  logic        din;
  logic        dout;
  logic [7:0]  g;
  logic [7:0]  r;
  logic [7:0]  b;
  logic        pix_valid;
  logic [15:0] pix_idx;
  logic        frame_done;
  logic        err;
  logic        busy;

  modport master (
    output din,
    input  dout, g, r, b, pix_valid, pix_idx,
    input  frame_done, err, busy
  );

  modport slave (
    input  din,
    output dout, g, r, b, pix_valid, pix_idx,
    output frame_done, err, busy
  );
endinterface

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchronizer for an async line, with one more flop
// to produce single-cycle rise/fall pulses.
module ws2812_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver acting as one chain pixel: decodes GRB words,
// detects the latch low and forwards bits after the first word.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned BIT_THRESH_TICKS = BIT_SPLIT_TICKS,
  parameter int unsigned GLITCH_TICKS     = 5,
  parameter int unsigned MAX_HIGH_TICKS   = 100,
  parameter int unsigned RESET_TICKS      = LATCH_TICKS,
  parameter int unsigned CNT_W            = 16
) (
  input logic        clk,
  input logic        rst_n,
  ws2812_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] THRESH =
    CNT_W'(BIT_THRESH_TICKS);
  localparam logic [CNT_W-1:0] GLITCH =
    CNT_W'(GLITCH_TICKS);
  localparam logic [CNT_W-1:0] MAX_HI =
    CNT_W'(MAX_HIGH_TICKS);
  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RESET_TICKS - 1);
  localparam logic [4:0] LAST_BIT =
    5'(WORD_BITS - 1);

  logic din_s;
  logic rise;
  logic fall;

  ws2812_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.din),
    .q_o    (din_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [22:0]      shift_q, shift_d;
  grb_t             grb_q, grb_d;
  logic [15:0]      idx_q, idx_d;
  logic             pv_q, pv_d;
  logic             fd_q, fd_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             fwd_q, fwd_d;
  logic             dout_q, dout_d;

  logic             bit_val;
  logic [23:0]      word;

  assign bit_val = (cnt_q >= THRESH);
  assign word    = {shift_q, bit_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      grb_q     <= '0;
      idx_q     <= '0;
      pv_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      fwd_q     <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      grb_q     <= grb_d;
      idx_q     <= idx_d;
      pv_q      <= pv_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      fwd_q     <= fwd_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    grb_d     = grb_q;
    idx_d     = idx_q;
    pv_d      = 1'b0;
    fd_d      = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    fwd_d     = fwd_q;

    if (pv_q && idx_q != 16'hFFFF) begin
      idx_d = idx_q + 16'd1;
    end

    unique case (state_q)
      ST_SYNC: begin
        if (din_s) begin
          cnt_d = '0;
        end else if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (rise) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (cnt_q > MAX_HI) begin
          err_d     = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          fwd_d     = 1'b0;
          state_d   = ST_SYNC;
        end else if (fall) begin
          cnt_d   = '0;
          state_d = ST_LOW;
          if (cnt_q >= GLITCH) begin
            shift_d = word[22:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              pv_d      = 1'b1;
              // Only the frame's first word is ours;
              // later words just report and pass on.
              if (!fwd_q) begin
                grb_d = to_grb(word);
                fwd_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LOW: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = ST_HIGH;
        end else if (cnt_q == RST_LAST) begin
          fd_d      = 1'b1;
          err_d     = (bit_cnt_q != 5'd0);
          cnt_d     = '0;
          bit_cnt_d = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          fwd_d     = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    dout_d = fwd_d & din_s;
  end

  assign bus.dout       = dout_q;
  assign bus.g          = grb_q.g;
  assign bus.r          = grb_q.r;
  assign bus.b          = grb_q.b;
  assign bus.pix_valid  = pv_q;
  assign bus.pix_idx    = idx_q;
  assign bus.frame_done = fd_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: directed pulse trains in,
// expected pixel/latch/error events checked by a monitor.
module tb_ws2812_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ws2812_rx_if bus ();

  ws2812_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  typedef logic [42:0] ev_t;

  ev_t         exp_q[$];
  int          checks      = 0;
  int          errors      = 0;
  int          pv_seen     = 0;
  int          dout_pulses = 0;
  int          dout_long   = 0;
  int          hi_len      = 0;
  logic [23:0] m_grb       = 24'h0;
  logic [15:0] m_idx       = 16'h0;
  logic        m_first     = 1'b1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Event = {pix_valid, frame_done, err, g, r, b, pix_idx}
  always @(negedge clk) begin
    if (rst_n && (bus.pix_valid || bus.frame_done || bus.err)) begin
      ev_t act;
      act = {bus.pix_valid, bus.frame_done, bus.err,
             bus.g, bus.r, bus.b, bus.pix_idx};
      if (bus.pix_valid) pv_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none",
                 act);
      end else begin
        chk("event", act, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus.dout) begin
      hi_len++;
    end else if (hi_len != 0) begin
      dout_pulses++;
      if (hi_len >= 30) dout_long++;
      hi_len = 0;
    end
  end

  task automatic exp_pix(input logic [23:0] w);
    if (m_first) m_grb = w;
    m_first = 1'b0;
    exp_q.push_back({3'b100, m_grb, m_idx});
    m_idx++;
  endtask

  task automatic exp_end(input logic fd, input logic er);
    exp_q.push_back({1'b0, fd, er, m_grb, 16'h0});
    m_idx   = 16'h0;
    m_first = 1'b1;
  endtask

  task automatic line(input logic v, input int n);
    bus.din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n,
                           input int spike_at);
    for (int i = 0; i < n; i++) begin
      logic b;
      int   lo;
      b  = w[23-i];
      lo = b ? 22 : 42;
      line(1'b1, b ? 40 : 20);
      if (i == spike_at) begin
        line(1'b0, 10);
        line(1'b1, 3);
        line(1'b0, lo - 13);
      end else begin
        line(1'b0, lo);
      end
    end
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 24, -1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk({"drain_", name}, exp_q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int v0;
    bus.din = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_state",
        {bus.g, bus.r, bus.b, bus.pix_idx, bus.pix_valid,
         bus.frame_done, bus.err, bus.busy, bus.dout}, 0);
    rst_n = 1'b1;

    // single word frame
    line(1'b0, 2600);
    chk("idle_busy", bus.busy, 0);
    exp_pix(24'hA53C0F);
    send_word(24'hA53C0F);
    chk("busy_in_frame", bus.busy, 1);
    exp_end(1'b1, 1'b0);
    line(1'b0, 2600);
    chk("busy_after_latch", bus.busy, 0);
    drain("single");

    // async reset in the middle of a word
    send_bits(24'hC3C3C3, 10, -1);
    line(1'b1, 10);
    chk("busy_mid_word", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_grb", {bus.g, bus.r, bus.b}, 0);
    chk("rst_async_ctl",
        {bus.pix_idx, bus.busy, bus.dout, bus.pix_valid,
         bus.frame_done, bus.err}, 0);
    m_grb = 24'h0;
    line(1'b1, 10);
    rst_n = 1'b1;
    v0 = pv_seen;
    line(1'b1, 20);
    line(1'b0, 22);
    send_word(24'hC3C3C3);
    chk("no_pix_before_sync", pv_seen - v0, 0);
    line(1'b0, 2600);
    drain("reset");

    // two words: first latched, second forwarded
    exp_pix(24'h112233);
    exp_pix(24'h445566);
    p0 = dout_pulses;
    v0 = dout_long;
    send_word(24'h112233);
    send_word(24'h445566);
    exp_end(1'b1, 1'b0);
    line(1'b0, 2600);
    chk("dout_pulses", dout_pulses - p0, 24);
    chk("dout_ones", dout_long - v0, 10);
    chk("hold_grb", {bus.g, bus.r, bus.b}, 24'h112233);
    drain("two_words");

    // short spike inside the low of bit 12
    exp_pix(24'h5AC381);
    send_bits(24'h5AC381, 24, 12);
    exp_end(1'b1, 1'b0);
    line(1'b0, 2600);
    drain("spike");

    // over-long high after 7 bits
    p0 = dout_pulses;
    v0 = pv_seen;
    send_bits(24'h6E0000, 7, -1);
    exp_end(1'b0, 1'b1);
    line(1'b1, 120);
    line(1'b0, 50);
    send_word(24'h123456);
    chk("err_dout_quiet", dout_pulses - p0, 0);
    chk("err_no_pix", pv_seen - v0, 0);
    line(1'b0, 2600);
    exp_pix(24'h0A0B0C);
    send_word(24'h0A0B0C);
    exp_end(1'b1, 1'b0);
    line(1'b0, 2600);
    drain("long_high");

    // partial word then latch
    send_bits(24'hF0F0F0, 12, -1);
    exp_end(1'b1, 1'b1);
    line(1'b0, 2600);
    chk("partial_idx", bus.pix_idx, 0);
    drain("partial");

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
